branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- EX-stage branch resolution controller for the pipelined RV32I core.
- Instantiates the existing branch comparator to resolve conditional branches, and maintains a direct-mapped table of 2-bit saturating counters that supplies direction predictions to fetch.
- Detects mispredictions and sequences a valid/ready redirect handshake to fetch, stalling EX until the redirect is accepted.

Parameters:
- IDX_BITS, 6, log2 of prediction table entries (64 entries). Index = pc[IDX_BITS+1:2].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_pc  in  32  PC being fetched
- if_pred_taken  out  1  prediction for if_pc; combinational table read, MSB of counter
- ex_br_valid  in  1  conditional branch present in EX
- ex_stall  in  1  EX held by the pipeline this cycle
- ex_br_op  in  branch_funct3_t  branch comparison op
- ex_rs1, ex_rs2  in  32  operands
- ex_pc  in  32  branch PC
- ex_target  in  32  taken target
- ex_pred_taken  in  1  prediction carried down the pipe with the branch
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  corrected PC
- redirect_ready  in  1  fetch accepts redirect
- flush  out  1  squash younger instructions
- stall_req  out  1  hold EX/earlier stages
- perf_branches  out  32  resolved-branch count (see Optional Feature)
- perf_mispredicts  out  32  mispredict count (see Optional Feature)

Behaviour:
- Reset:
  - All table counters set to 2'b01 (weakly not-taken).
  - State RUN.
  - redirect_valid=0, redirect_pc=0, flush=0, stall_req=0, perf counters=0.
- Resolve event: ex_br_valid && !ex_stall && state==RUN. Exactly one update per branch instance.
- On a resolve event (cycle N):
  - taken = cmp output.
  - Counter at idx(ex_pc) increments on taken, decrements on not-taken, saturating at 00 and 11.
  - mispredict = taken != ex_pred_taken.
- Misprediction:
  - At N+1: redirect_valid=1, state REDIR_WAIT, redirect_pc = taken ? ex_target : ex_pc+4 (mod 2^32, wraps).
  - Outputs are registered.
- State machine, two states (RUN, REDIR_WAIT):
  - RUN -> REDIR_WAIT on a mispredicting resolve event.
  - REDIR_WAIT -> RUN on the cycle redirect_valid && redirect_ready. redirect_valid deasserts next cycle.
  - redirect_valid and redirect_pc are held stable while ready=0.
- stall_req = (state==REDIR_WAIT), combinational.
- flush = redirect_valid && redirect_ready, combinational, one cycle per redirect.
- Branches presented during REDIR_WAIT are ignored: no update, no count. They are younger and flushed.
- Read/update collision: same-cycle predict and update to the same index returns the pre-update value to if_pred_taken.
- Correct prediction: no redirect, no stall; state stays RUN.
- ex_stall=1 with ex_br_valid=1: no update; resolution occurs on the first unstalled cycle.
- rst asserted mid-REDIR_WAIT: returns to RUN, drops redirect_valid, and reinitialises the table.
- Invalid ex_br_op (funct3 010/011): taken=0.

Optional Feature:
- Macro BRANCH_PERF_CNT_EN.
- Defined:
  - perf_branches increments on every resolve event.
  - perf_mispredicts increments on every mispredicting resolve event.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, and are cleared by rst.
- Undefined: counters are not built and both ports are tied to 0. Ports remain present.

Decomposition:
- rv32i_types gains:
  - bp_state_t enum {RUN, REDIR_WAIT}.
  - Constant BP_CNT_INIT = 2'b01.
  - sat2_t typedef for the 2-bit counter.
- branch_funct3_t is reused from rv32i_types.
- The existing cmp module is instantiated unchanged.
- One natural new sub-module: bp_sat_counter2 (next-value logic for the 2-bit saturating counter).

Test Plan:
- After reset, if_pc=0x100 -> if_pred_taken=0. Hold rst mid-operation -> all outputs 0 next cycle.
- BEQ rs1=rs2=5, pc=0x100, target=0x140, pred=0 -> at N+1 redirect_valid=1, redirect_pc=0x140, stall_req=1. ready=1 at N+3 -> flush pulse at N+3, RUN at N+4. Counter becomes 10, so if_pc=0x100 predicts 1.
- BLT rs1=0xFFFFFFFF, rs2=1 (taken), pred=1 -> no redirect. BLTU same operands, pred=1 -> redirect_pc=pc+4.
- Four taken resolves on one index -> counter saturates at 11. Then one not-taken -> 10, prediction still taken.
- Mispredict with ready held low for 5 cycles -> redirect_valid and redirect_pc stable. A second ex_br_valid during the wait -> no table change and no count.
- With BRANCH_PERF_CNT_EN defined: 10 branches, 3 mispredicted -> perf_branches=10, perf_mispredicts=3. With counter preloaded to 0xFFFFFFFF, one more branch -> wraps to 0. Macro undefined -> both read 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch funct3 encodings and branch-predictor state/counter types.
package rv32i_types;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } branch_funct3_t;

   typedef enum logic {
      RUN        = 1'b0,
      REDIR_WAIT = 1'b1
   } bp_state_t;

   typedef logic [1:0] sat2_t;

   localparam sat2_t BP_CNT_INIT = 2'b01;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-value logic for a 2-bit saturating direction counter (00 strong NT .. 11 strong T).
module bp_sat_counter2
   import rv32i_types::*;
(
   input  logic [1:0] cnt_in,
   input  logic       taken,
   output logic [1:0] cnt_out
);

   always_comb begin
      cnt_out = cnt_in;
      if (taken) begin
         if (cnt_in != 2'b11) cnt_out = cnt_in + 2'b01;
      end else begin
         if (cnt_in != 2'b00) cnt_out = cnt_in - 2'b01;
      end
   end

endmodule

// File: rtl/cmp.sv
// RV32I conditional-branch comparator; reserved funct3 encodings resolve as not-taken.
module cmp
   import rv32i_types::*;
(
   input  branch_funct3_t op,
   input  logic [31:0]    a,
   input  logic [31:0]    b,
   output logic           taken
);

   always_comb begin
      taken = 1'b0;
      case (op)
         BR_BEQ:  taken = (a == b);
         BR_BNE:  taken = (a != b);
         BR_BLT:  taken = ($signed(a) <  $signed(b));
         BR_BGE:  taken = ($signed(a) >= $signed(b));
         BR_BLTU: taken = (a <  b);
         BR_BGEU: taken = (a >= b);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution, 2-bit counter prediction table and fetch redirect handshake.
// Optional performance counters are built when BRANCH_PERF_CNT_EN is defined.
module branch_resolve_ctrl
   import rv32i_types::*;
#(
   parameter int IDX_BITS = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [31:0]    if_pc,
   output logic           if_pred_taken,
   input  logic           ex_br_valid,
   input  logic           ex_stall,
   input  branch_funct3_t ex_br_op,
   input  logic [31:0]    ex_rs1,
   input  logic [31:0]    ex_rs2,
   input  logic [31:0]    ex_pc,
   input  logic [31:0]    ex_target,
   input  logic           ex_pred_taken,
   output logic           redirect_valid,
   output logic [31:0]    redirect_pc,
   input  logic           redirect_ready,
   output logic           flush,
   output logic           stall_req,
   output logic [31:0]    perf_branches,
   output logic [31:0]    perf_mispredicts
);

   localparam int ENTRIES = 1 << IDX_BITS;

   bp_state_t               state_q, state_d;
   logic [31:0]             redirect_pc_q, redirect_pc_d;
   logic [IDX_BITS-1:0]     if_idx, ex_idx;
   logic [2*ENTRIES-1:0]    table_flat;
   sat2_t                   cnt_cur, cnt_next;
   logic                    taken, resolve, mispredict;
   logic                    unused_if_pc_bits;

   assign if_idx            = if_pc[IDX_BITS+1:2];
   assign ex_idx            = ex_pc[IDX_BITS+1:2];
   assign unused_if_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

   cmp u_cmp (
      .op    (ex_br_op),
      .a     (ex_rs1),
      .b     (ex_rs2),
      .taken (taken)
   );

   // Branches seen while a redirect is outstanding are younger and about to be squashed.
   assign resolve    = ex_br_valid && !ex_stall && (state_q == RUN);
   assign mispredict = resolve && (taken != ex_pred_taken);

   assign cnt_cur = table_flat[{ex_idx, 1'b0} +: 2];

   bp_sat_counter2 u_sat (
      .cnt_in  (cnt_cur),
      .taken   (taken),
      .cnt_out (cnt_next)
   );

   // Reads see the registered table, so a same-cycle update to the fetched index is not forwarded.
   assign if_pred_taken = table_flat[{if_idx, 1'b1}];

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         sat2_t ent_q, ent_d;

         always_comb begin
            ent_d = ent_q;
            if (resolve && (ex_idx == IDX_BITS'(gi))) ent_d = cnt_next;
         end

         always_ff @(posedge clk) begin
            if (rst) ent_q <= BP_CNT_INIT;
            else     ent_q <= ent_d;
         end

         assign table_flat[2*gi +: 2] = ent_q;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         redirect_pc_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         RUN: begin
            if (mispredict) begin
               state_d       = REDIR_WAIT;
               redirect_pc_d = taken ? ex_target : (ex_pc + 32'd4);
            end
         end
         REDIR_WAIT: begin
            if (redirect_ready) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      redirect_valid = (state_q == REDIR_WAIT);
      redirect_pc    = redirect_pc_q;
      stall_req      = (state_q == REDIR_WAIT);
      flush          = redirect_valid && redirect_ready;
   end

`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] perf_br_q, perf_br_d;
   logic [31:0] perf_mp_q, perf_mp_d;

   always_comb begin
      perf_br_d = perf_br_q + {31'd0, resolve};
      perf_mp_d = perf_mp_q + {31'd0, mispredict};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_br_q <= 32'd0;
         perf_mp_q <= 32'd0;
      end else begin
         perf_br_q <= perf_br_d;
         perf_mp_q <= perf_mp_d;
      end
   end

   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mp_q;
`else
   assign perf_branches    = 32'd0;
   assign perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed scenarios followed by randomized traffic.
module tb_branch_resolve_ctrl;
   import rv32i_types::*;

   logic           clk = 1'b0;
   logic           rst;
   logic [31:0]    if_pc;
   logic           if_pred_taken;
   logic           ex_br_valid;
   logic           ex_stall;
   branch_funct3_t ex_br_op;
   logic [31:0]    ex_rs1, ex_rs2, ex_pc, ex_target;
   logic           ex_pred_taken;
   logic           redirect_valid;
   logic [31:0]    redirect_pc;
   logic           redirect_ready;
   logic           flush;
   logic           stall_req;
   logic [31:0]    perf_branches, perf_mispredicts;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.IDX_BITS(6)) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc            (if_pc),
      .if_pred_taken    (if_pred_taken),
      .ex_br_valid      (ex_br_valid),
      .ex_stall         (ex_stall),
      .ex_br_op         (ex_br_op),
      .ex_rs1           (ex_rs1),
      .ex_rs2           (ex_rs2),
      .ex_pc            (ex_pc),
      .ex_target        (ex_target),
      .ex_pred_taken    (ex_pred_taken),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .redirect_ready   (redirect_ready),
      .flush            (flush),
      .stall_req        (stall_req),
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
   );

   typedef struct {
      bit        pred;
      bit        rvalid;
      bit [31:0] rpc;
      bit        flush;
      bit        stall;
      bit [31:0] pb;
      bit [31:0] pm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: counter values per table slot, pending-redirect flag, event counts.
   int        m_cnt[64];
   bit        m_wait;
   bit [31:0] m_rpc;
   bit [31:0] m_nb, m_nm;

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) m_cnt[i] = 1;
      m_wait = 0;
      m_rpc  = 32'd0;
      m_nb   = 32'd0;
      m_nm   = 32'd0;
   endfunction

   function automatic int slot(bit [31:0] pc);
      return int'(pc[7:2]);
   endfunction

   function automatic bit ref_taken(bit [2:0] f, bit [31:0] a, bit [31:0] b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void chk(string name, bit [31:0] act, bit [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endfunction

   // Drives one cycle (called just after a rising edge) and queues that cycle's expected outputs.
   task automatic step(bit r, bit [31:0] ipc, bit v, bit st, bit [2:0] f,
                       bit [31:0] a, bit [31:0] b, bit [31:0] pc, bit [31:0] tgt,
                       bit pr, bit rdy);
      exp_t e;
      bit   tk;
      rst            = r;
      if_pc          = ipc;
      ex_br_valid    = v;
      ex_stall       = st;
      ex_br_op       = branch_funct3_t'(f);
      ex_rs1         = a;
      ex_rs2         = b;
      ex_pc          = pc;
      ex_target      = tgt;
      ex_pred_taken  = pr;
      redirect_ready = rdy;

      e.pred   = (m_cnt[slot(ipc)] >= 2);
      e.rvalid = m_wait;
      e.rpc    = m_rpc;
      e.flush  = m_wait && rdy;
      e.stall  = m_wait;
`ifdef BRANCH_PERF_CNT_EN
      e.pb = m_nb;
      e.pm = m_nm;
`else
      e.pb = 32'd0;
      e.pm = 32'd0;
`endif
      exp_q.push_back(e);

      if (r) begin
         model_reset();
      end else if (m_wait) begin
         if (rdy) m_wait = 0;
      end else if (v && !st) begin
         tk = ref_taken(f, a, b);
         m_nb++;
         if (tk) m_cnt[slot(pc)] = (m_cnt[slot(pc)] == 3) ? 3 : m_cnt[slot(pc)] + 1;
         else    m_cnt[slot(pc)] = (m_cnt[slot(pc)] == 0) ? 0 : m_cnt[slot(pc)] - 1;
         if (tk != pr) begin
            m_nm++;
            m_wait = 1;
            m_rpc  = tk ? tgt : pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(bit [31:0] ipc, bit rdy);
      step(1'b0, ipc, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, rdy);
   endtask

   task automatic br(bit [31:0] ipc, bit [2:0] f, bit [31:0] a, bit [31:0] b,
                     bit [31:0] pc, bit [31:0] tgt, bit pr, bit rdy);
      step(1'b0, ipc, 1'b1, 1'b0, f, a, b, pc, tgt, pr, rdy);
   endtask

   // Monitor: compares whatever expectation is queued for the current cycle, mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, e.pred});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rvalid});
            chk("stall_req", {31'd0, stall_req}, {31'd0, e.stall});
            chk("flush", {31'd0, flush}, {31'd0, e.flush});
            chk("perf_branches", perf_branches, e.pb);
            chk("perf_mispredicts", perf_mispredicts, e.pm);
            if (e.rvalid) chk("redirect_pc", redirect_pc, e.rpc);
            if (e.flush) $display("redirect accepted pc=%h t=%0t", redirect_pc, $time);
         end
      end
   end

   initial begin
      bit [31:0] a, b, pc, ipc;
      rst = 1'b1; if_pc = 32'd0; ex_br_valid = 1'b0; ex_stall = 1'b0;
      ex_br_op = BR_BEQ; ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_pc = 32'd0;
      ex_target = 32'd0; ex_pred_taken = 1'b0; redirect_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      idle(32'h100, 1'b0);
      // BEQ taken, predicted not-taken; fetch accepts two cycles after the request appears.
      br(32'h100, 3'd0, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0, 1'b0);
      idle(32'h100, 1'b0);
      idle(32'h100, 1'b0);
      idle(32'h100, 1'b1);
      idle(32'h100, 1'b0);
      // Signed vs unsigned compare of the same operands.
      br(32'h200, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h280, 1'b1, 1'b0);
      br(32'h200, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h280, 1'b1, 1'b1);
      idle(32'h200, 1'b0);
      // Saturation: four taken, then one not-taken, on the same slot with fetch colliding.
      repeat (4) br(32'h300, 3'd1, 32'd1, 32'd2, 32'h300, 32'h3F0, 1'b1, 1'b0);
      br(32'h300, 3'd1, 32'd7, 32'd7, 32'h300, 32'h3F0, 1'b0, 1'b0);
      idle(32'h300, 1'b0);
      // Long wait with a younger branch arriving mid-wait; it must be ignored.
      br(32'h400, 3'd7, 32'd9, 32'd3, 32'hFFFF_FFFC, 32'h500, 1'b0, 1'b0);
      idle(32'h400, 1'b0);
      br(32'h400, 3'd0, 32'd1, 32'd1, 32'h400, 32'h440, 1'b0, 1'b0);
      repeat (3) idle(32'h400, 1'b0);
      idle(32'h3FC, 1'b1);
      // Reserved funct3 resolves not-taken; then reset lands during the wait.
      br(32'h500, 3'd2, 32'd4, 32'd4, 32'h500, 32'h600, 1'b1, 1'b0);
      idle(32'h300, 1'b0);
      step(1'b1, 32'h300, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      idle(32'h300, 1'b0);
      idle(32'h100, 1'b1);

      for (int i = 0; i < 400; i++) begin
         pc  = 32'h1000 + ($urandom_range(0, 7) << 2);
         if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
         ipc = ($urandom_range(0, 2) == 0) ? pc : 32'h1000 + ($urandom_range(0, 7) << 2);
         a   = $urandom_range(0, 3) == 0 ? $urandom() : $urandom_range(0, 4);
         b   = $urandom_range(0, 2) == 0 ? a : $urandom_range(0, 4);
         step($urandom_range(0, 99) == 0, ipc, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), a, b, pc,
              $urandom(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
